// File: rtl/aes_pkg.sv
// Shared AES constants: mode encodings, Nk/Nr per mode, Rcon table and S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  localparam int unsigned NK_128 = 4;
  localparam int unsigned NK_192 = 6;
  localparam int unsigned NK_256 = 8;
  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  // Rcon[1..10], first byte is Rcon[1]
  localparam logic [0:79] RCON_TABLE = 80'h01020408102040801b36;

  // Forward S-box, byte 0 leftmost
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{x, 3'b000} +: 8];
  endfunction

  // idx 0 selects Rcon[1]
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON_TABLE[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] nk_of_mode(input mode_t m);
    case (m)
      MODE_128: return 4'(NK_128);
      MODE_192: return 4'(NK_192);
      MODE_256: return 4'(NK_256);
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of_mode(input mode_t m);
    case (m)
      MODE_128: return 4'(NR_128);
      MODE_192: return 4'(NR_192);
      MODE_256: return 4'(NR_256);
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Control/status and round-key read bus of the key schedule engine.
interface aes_key_schedule_if;
  logic           start;
  aes_pkg::mode_t mode;
  logic [0:255]   key;
  logic           busy;
  logic           done;
  logic           err;
  logic           keys_valid;
  logic [3:0]     rk_idx;
  logic [0:127]   rk_data;

  modport master (
    output start, mode, key, rk_idx,
    input  busy, done, err, keys_valid, rk_data
  );

  modport slave (
    input  start, mode, key, rk_idx,
    output busy, done, err, keys_valid, rk_data
  );
endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] result
);

  // One S-box per byte lane
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign result[8*b +: 8] = sbox(word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one word per clock, with a
// registered random-access round-key read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK = 8
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_schedule_if.slave  bus
);

  localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t        state;
  logic [31:0]   words [DEPTH];
  logic [3:0]    nk;
  logic [3:0]    nr;
  logic [AW-1:0] idx;
  logic [AW-1:0] last_idx;
  logic [2:0]    wrap;
  logic [3:0]    rcon_idx;
  logic          busy;
  logic          done;
  logic          err;
  logic          keys_valid;
  logic [0:127]  rk_data;

  logic [3:0]    mode_nk;
  logic [3:0]    mode_nr;
  logic [AW-1:0] mode_last;
  logic          mode_ok;
  logic          accept;
  logic          reject;
  logic [31:0]   prev;
  logic [31:0]   back;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp;
  logic [31:0]   next_word;
  logic [AW-1:0] rk_base;

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.keys_valid = keys_valid;
  assign bus.rk_data    = rk_data;

  // Start qualification against the instance's supported key sizes
  always_comb begin
    mode_nk   = nk_of_mode(bus.mode);
    mode_nr   = nr_of_mode(bus.mode);
    mode_last = AW'(32'(mode_nr) * 4 + 3);
    mode_ok   = (bus.mode != MODE_RSVD) && (32'(mode_nk) <= MAX_NK);
    accept    = (state == IDLE) && bus.start && mode_ok;
    reject    = (state == IDLE) && bus.start && !mode_ok;
  end

  // Next schedule word; wrap == i mod Nk, rcon_idx == i/Nk - 1
  always_comb begin
    prev   = words[idx - AW'(1)];
    back   = words[idx - AW'(nk)];
    sub_in = (wrap == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    if (wrap == 3'd0) begin
      temp = sub_out ^ {rcon(rcon_idx), 24'h000000};
    end else if ((nk == 4'd8) && (wrap == 3'd4)) begin
      temp = sub_out;
    end else begin
      temp = prev;
    end
    next_word = back ^ temp;
  end

  aes_sub_word u_sub_word (
    .word   (sub_in),
    .result (sub_out)
  );

  // Control FSM, counters and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_valid <= 1'b0;
      nk         <= 4'd0;
      nr         <= 4'd0;
      idx        <= '0;
      last_idx   <= '0;
      wrap       <= 3'd0;
      rcon_idx   <= 4'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            nk         <= mode_nk;
            nr         <= mode_nr;
            idx        <= AW'(mode_nk);
            last_idx   <= mode_last;
            wrap       <= 3'd0;
            rcon_idx   <= 4'd0;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end else if (reject) begin
            err <= 1'b1;
          end
        end
        EXPAND: begin
          idx <= idx + AW'(1);
          if ({1'b0, wrap} == (nk - 4'd1)) begin
            wrap     <= 3'd0;
            rcon_idx <= rcon_idx + 4'd1;
          end else begin
            wrap <= wrap + 3'd1;
          end
          if (idx == last_idx) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word storage: key words on the accepting edge, then one derived word per cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned j = 0; j < 8; j++) begin
        if (j < 32'(mode_nk)) begin
          words[AW'(j)] <= bus.key[32*j +: 32];
        end
      end
    end else if (state == EXPAND) begin
      words[idx] <= next_word;
    end
  end

  assign rk_base = AW'({rk_idx_clamped(bus.rk_idx, nr), 2'b00});

  function automatic logic [3:0] rk_idx_clamped(input logic [3:0] r, input logic [3:0] lim);
    return (r > lim) ? 4'd0 : r;
  endfunction

  // Registered round-key read; zero when invalid or out of range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_data <= '0;
    end else if (keys_valid && (bus.rk_idx <= nr)) begin
      rk_data <= {words[rk_base], words[rk_base + AW'(1)],
                  words[rk_base + AW'(2)], words[rk_base + AW'(3)]};
    end else begin
      rk_data <= '0;
    end
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative, multi-mode AES key expansion engine: accepts a 128/192/256-bit cipher key, generates the full FIPS-197 word schedule at one 32-bit word per clock into internal storage, and serves round keys through a registered random-access read port. It is the successor to the fully combinational 128-bit KeyExpansion block. It feeds the round datapath of the cipher core, trading combinational depth for sequential latency and adding AES-192/256 support.

## Interface
- MAX_NK, default 8: largest key length in 32-bit words the instance supports; legal values 4, 6, 8. Storage depth is 4*(MAX_NK+7) words.
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request expansion; sampled only when busy=0.
- mode  input  2  key size: 0=AES-128 (Nk=4), 1=AES-192 (Nk=6), 2=AES-256 (Nk=8), 3=reserved.
- key  input  [0:255]  cipher key, MSB-first; word w0=key[0:31]; AES-128 uses key[0:127], AES-192 uses key[0:191]; unused bits ignored.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse, schedule complete.
- err  output  1  one-cycle pulse, start rejected.
- keys_valid  output  1  level, stored schedule is complete and readable.
- rk_idx  input  4  round-key index r, 0..Nr.
- rk_data  output  [0:127]  round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Operation
- Nr = Nk+6; total words T = 4(Nr+1) = 44/52/60; generated words G = T-Nk = 40/46/52.
- States: IDLE, EXPAND.
  - IDLE, start=1, legal mode: on that edge write w0..w(Nk-1) from key, latch Nk, set i=Nk, clear keys_valid, set busy, go to EXPAND.
  - IDLE, start=1, mode=3 or Nk>MAX_NK: err pulses next cycle; no state change; keys_valid and stored words untouched.
  - EXPAND: each edge writes w[i]; i increments. On the edge writing w[T-1]: go to IDLE, clear busy, set done (one cycle) and keys_valid.
- Word rule: temp=w[i-1]; if i mod Nk==0: temp=SubWord(RotWord(temp)) xor {Rcon[i/Nk],24'h0}; else if Nk==8 and i mod 8==4: temp=SubWord(temp); w[i]=w[i-Nk] xor temp.
- i mod Nk and i/Nk are tracked by a wrap counter (0..Nk-1) and an Rcon index counter; no divider.
- start while busy=1 is ignored: no err, no restart.
- Restart from IDLE with keys_valid=1 is legal; keys_valid drops on the accepting edge.
- Read port: rk_data registered; returns zero when keys_valid=0 or rk_idx>Nr.

## Timing
- Reset values: busy=0, done=0, err=0, keys_valid=0, rk_data=0, state=IDLE, counters=0. Word storage is not cleared.
- Counting the start-sampling edge as edge 0, done and keys_valid are visible after edge G: 40 (AES-128), 46 (AES-192), 52 (AES-256). busy is high after edges 0..G-1.
- rk_data latency: 1 cycle from rk_idx.
- Reset asserted mid-expansion: immediate return to IDLE with all outputs at reset values. The partial schedule is never reported valid.
- One SubWord (4 S-box lookups) per cycle; this is the critical path.

## Structure
- Shared package aes_pkg: Rcon table (10 entries), mode encodings, NK/NR constants per mode, S-box function or table.
- One sub-module, aes_sub_word: 32-bit combinational SubWord built from four S-box instances. It is reused by the cipher round logic.
- Storage: register array of 4*(MAX_NK+7) 32-bit words. Synthesis may map it to distributed RAM only if the read port is kept registered.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done after 40 edges; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-128, all-zero key -> rk_idx=0 gives 0; rk_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 edges; last word of rk_idx=12 is 01002202; rk_idx=13 gives 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 edges; last word of rk_idx=14 is 706c631e.
- mode=3 start -> err pulses one cycle; busy stays 0. Next, MAX_NK=4 instance with mode=2 -> err pulses; keys_valid unchanged.
- Reset asserted at edge 20 of an AES-256 run -> all outputs 0 immediately. Start pulses during busy are ignored. A fresh AES-128 run afterwards matches the first vector.
